// File: rtl/snn_uart_loader.sv
// snn_uart_loader: unpacks UART bytes into pixels for the SNN input RAM, starts the core and returns its digit over UART
module snn_uart_loader #(
    parameter int NUM_PIX = 784,
    parameter int PIX_W   = 1,
    parameter int ADDR_W  = 10,
    parameter int RES_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    input  logic              tx_rdy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_done,
    input  logic [RES_W-1:0]  core_digit,
    output logic              core_start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              ram_we,
    output logic              busy,
    output logic              overrun,
    input  logic              clr_err,
    output logic [7:0]        result
);
    typedef enum logic [2:0] {IDLE, UNPACK, WAIT, START, RUN, SEND} state_t;
    localparam int PPB = 8 / PIX_W;
    state_t            state;
    logic [7:0]        shift;
    logic [7:0]        hold;
    logic              hold_full;
    logic [2:0]        pix_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic              byte_done;
    logic              last;
    logic              drop;
    assign byte_done = pix_cnt == 3'(PPB - 1);
    assign last      = wr_addr == ADDR_W'(NUM_PIX - 1);
    assign drop      = rx_rdy && ((state == UNPACK && hold_full && !(byte_done && !last)) ||
                                  state == START || state == RUN || state == SEND);
    assign ram_we    = state == UNPACK;
    assign ram_wdata = ram_we ? shift[PIX_W-1:0] : '0;
    assign ram_addr  = ram_we ? wr_addr : core_addr;
    assign busy      = state != IDLE;
    // frame FSM: byte capture, pixel unpack with one-byte hold buffer, core handshake, result send
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            pix_cnt    <= '0;
            wr_addr    <= '0;
            core_start <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            result     <= '0;
            overrun    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            tx_start   <= 1'b0;
            overrun    <= drop | (overrun & ~clr_err);
            case (state)
                IDLE, WAIT: if (rx_rdy) begin
                    shift   <= rx_data;
                    pix_cnt <= '0;
                    state   <= UNPACK;
                end
                UNPACK: begin
                    if (last) begin
                        state      <= START;
                        core_start <= 1'b1;
                        hold_full  <= 1'b0;
                        pix_cnt    <= '0;
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        if (byte_done) begin
                            pix_cnt <= '0;
                            if (hold_full) begin
                                shift     <= hold;
                                hold      <= rx_data;
                                hold_full <= rx_rdy;
                            end else if (rx_rdy) begin
                                shift <= rx_data;
                            end else begin
                                state <= WAIT;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + 3'd1;
                            shift   <= shift >> PIX_W;
                            if (rx_rdy && !hold_full) begin
                                hold      <= rx_data;
                                hold_full <= 1'b1;
                            end
                        end
                    end
                end
                START: begin
                    wr_addr <= '0;
                    state   <= RUN;
                end
                RUN: if (core_done) begin
                    result  <= 8'(core_digit);
                    tx_data <= 8'(core_digit);
                    state   <= SEND;
                end
                SEND: if (tx_rdy) begin
                    tx_start <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_uart_loader.sv
// tb_snn_uart_loader: directed checks of the UART-to-SNN loader at PIX_W=1 (full frame) and PIX_W=4 (short frame)
module tb_snn_uart_loader;
    logic clk, rst_n;
    int n_chk = 0, n_pass = 0;

    logic [7:0] a_rx_data, a_tx_data, a_result;
    logic       a_rx_rdy, a_tx_rdy, a_tx_start, a_core_done, a_core_start, a_we, a_busy, a_overrun, a_clr_err;
    logic [9:0] a_core_addr, a_addr;
    logic [3:0] a_core_digit;
    logic [0:0] a_wdata;

    logic [7:0] b_rx_data, b_tx_data, b_result;
    logic       b_rx_rdy, b_tx_rdy, b_tx_start, b_core_done, b_core_start, b_we, b_busy, b_overrun, b_clr_err;
    logic [2:0] b_core_addr, b_addr;
    logic [3:0] b_core_digit, b_wdata;

    snn_uart_loader u_a (
        .clk(clk), .rst_n(rst_n), .rx_data(a_rx_data), .rx_rdy(a_rx_rdy), .tx_rdy(a_tx_rdy),
        .tx_start(a_tx_start), .tx_data(a_tx_data), .core_addr(a_core_addr), .core_done(a_core_done),
        .core_digit(a_core_digit), .core_start(a_core_start), .ram_addr(a_addr), .ram_wdata(a_wdata),
        .ram_we(a_we), .busy(a_busy), .overrun(a_overrun), .clr_err(a_clr_err), .result(a_result)
    );

    snn_uart_loader #(.NUM_PIX(5), .PIX_W(4), .ADDR_W(3), .RES_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .rx_data(b_rx_data), .rx_rdy(b_rx_rdy), .tx_rdy(b_tx_rdy),
        .tx_start(b_tx_start), .tx_data(b_tx_data), .core_addr(b_core_addr), .core_done(b_core_done),
        .core_digit(b_core_digit), .core_start(b_core_start), .ram_addr(b_addr), .ram_wdata(b_wdata),
        .ram_we(b_we), .busy(b_busy), .overrun(b_overrun), .clr_err(b_clr_err), .result(b_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write/pulse monitors, sampled on the falling edge
    logic a_mem [0:1023];
    int   a_wcnt = 0, a_maxaddr = 0, a_starts = 0, a_txs = 0;
    int   b_cnt = 0, b_starts = 0;
    logic [2:0] b_addr_log [0:15];
    logic [3:0] b_data_log [0:15];
    always @(negedge clk) begin
        if (a_we) begin
            a_wcnt++;
            a_mem[a_addr] = a_wdata[0];
            if (int'(a_addr) > a_maxaddr) a_maxaddr = int'(a_addr);
        end
        if (a_core_start) a_starts++;
        if (a_tx_start) a_txs++;
        if (b_we && b_cnt < 16) begin
            b_addr_log[b_cnt] = b_addr;
            b_data_log[b_cnt] = b_wdata;
            b_cnt++;
        end
        if (b_core_start) b_starts++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_a(input logic [7:0] b);
        @(negedge clk);
        a_rx_data = b;
        a_rx_rdy  = 1'b1;
        @(negedge clk);
        a_rx_rdy  = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        @(negedge clk);
        b_rx_data = b;
        b_rx_rdy  = 1'b1;
        @(negedge clk);
        b_rx_rdy  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // rx pulses at cycles 0, 2 (and 4 when n_rx==3); optional clr_err at cycle 4; collects writes over 20 cycles
    task automatic burst(input int n_rx, input logic clr4, output int w, output logic [15:0] seq, output logic gap);
        logic [7:0] bytes [0:2];
        int last_c;
        bytes[0] = 8'h3C; bytes[1] = 8'hC3; bytes[2] = 8'h99;
        w = 0; seq = '0; gap = 1'b0; last_c = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            a_rx_rdy  = (c % 2 == 0) && (c / 2 < n_rx);
            a_rx_data = bytes[(c / 2) % 3];
            a_clr_err = clr4 && c == 4;
            if (a_we) begin
                if (w < 16) seq[w] = a_wdata[0];
                if (w > 0 && last_c != c - 1) gap = 1'b1;
                last_c = c;
                w++;
            end
        end
        @(negedge clk);
        a_rx_rdy = 1'b0; a_clr_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, w;
        logic [15:0] seq;
        logic gap, hit;
        logic [7:0] v;
        rst_n = 1'b0;
        a_rx_data = '0; a_rx_rdy = 0; a_tx_rdy = 0; a_core_done = 0; a_core_digit = '0; a_clr_err = 0;
        a_core_addr = 10'h155;
        b_rx_data = '0; b_rx_rdy = 0; b_tx_rdy = 0; b_core_done = 0; b_core_digit = '0; b_clr_err = 0;
        b_core_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_we", a_we, 0);
        check("rst_wdata", a_wdata, 0);
        check("rst_ram_addr", a_addr, 10'h155);
        check("rst_outs", {a_tx_start, a_core_start, a_overrun}, 0);
        check("rst_result", a_result, 0);
        check("rst_tx_data", a_tx_data, 0);
        rst_n = 1'b1;

        // PIX_W=4, NUM_PIX=5: pixel 6 discarded
        send_b(8'h21); send_b(8'h43); send_b(8'h65);
        repeat (3) @(negedge clk);
        check("b_writes", b_cnt, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("b_addr%0d", i), b_addr_log[i], i);
            check($sformatf("b_data%0d", i), b_data_log[i], i + 1);
        end
        check("b_starts", b_starts, 1);
        check("b_busy_run", b_busy, 1);

        // PIX_W=1 full frame of 0xA5
        base = a_wcnt;
        for (int i = 0; i < 98; i++) begin
            send_a(8'hA5);
            repeat (9) @(negedge clk);
        end
        check("a_frame_writes", a_wcnt - base, 784);
        check("a_max_addr", a_maxaddr, 783);
        for (int i = 0; i < 8; i++) v[i] = a_mem[i];
        check("a_pix0_7", v, 8'hA5);
        check("a_pix783", a_mem[783], 1);
        check("a_starts", a_starts, 1);
        check("a_busy_run", a_busy, 1);
        check("a_ram_addr_run", a_addr, 10'h155);

        // byte during RUN is dropped
        send_a(8'h11);
        @(negedge clk);
        check("a_ovr_run", a_overrun, 1);
        a_clr_err = 1'b1;
        @(negedge clk);
        a_clr_err = 1'b0;
        @(negedge clk);
        check("a_ovr_clr_run", a_overrun, 0);

        // result return with TX held busy
        base = a_txs;
        a_core_digit = 4'd7; a_core_done = 1'b1;
        @(negedge clk);
        a_core_done = 1'b0;
        repeat (10) @(negedge clk);
        check("a_tx_wait", a_txs - base, 0);
        check("a_result", a_result, 8'h07);
        check("a_tx_data", a_tx_data, 8'h07);
        a_tx_rdy = 1'b1;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            hit = a_tx_start;
        end
        a_tx_rdy = 1'b0;
        check("a_tx_start", hit, 1);
        @(negedge clk);
        check("a_tx_once", a_txs - base, 1);
        check("a_idle", a_busy, 0);

        // async reset at pixel 300
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            send_a(8'h5A);
            for (int k = 0; k < 10 && !hit; k++) begin
                if (a_we && a_addr == 10'd300) hit = 1;
                else @(negedge clk);
            end
        end
        check("a_hit300", hit, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_we", a_we, 0);
        check("mid_rst_result", a_result, 0);
        check("mid_rst_ram_addr", a_addr, 10'h155);
        @(negedge clk);
        rst_n = 1'b1;
        send_a(8'hFF);
        check("new_frame_we", a_we, 1);
        check("new_frame_addr", a_addr, 0);
        repeat (9) @(negedge clk);

        // two bytes 2 cycles apart: 16 back-to-back writes
        burst(2, 0, w, seq, gap);
        check("b2b_writes", w, 16);
        check("b2b_gap", gap, 0);
        check("b2b_data", seq, 16'hC33C);
        check("b2b_ovr", a_overrun, 0);
        check("b2b_wait", {a_busy, a_we}, 2'b10);

        // third byte while hold buffer full
        burst(3, 0, w, seq, gap);
        check("ovr_writes", w, 16);
        check("ovr_set", a_overrun, 1);
        a_clr_err = 1'b1;
        @(negedge clk);
        a_clr_err = 1'b0;
        @(negedge clk);
        check("ovr_clr", a_overrun, 0);

        // clear and drop in the same cycle: set wins
        burst(3, 1, w, seq, gap);
        check("ovr_set_wins", a_overrun, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
